// File: rtl/mvm_sequencer.sv
// Sequencer for an N x N matrix-vector multiplier: buffers A (row-major) and B, streams one column per
// cycle, waits LAT cycles, then drains the serial result chain. `MVM_SEQ_PERF_CNT_EN adds a job_cnt output.
module mvm_sequencer #(
    parameter int N   = 3,
    parameter int DW  = 8,
    parameter int LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [DW-1:0]             in_data,
    output logic                      in_ready,
    output logic [DW-1:0]             mat_a [0:N-1],
    output logic [DW-1:0]             vect_b,
    output logic                      init,
    output logic                      shift_en,
    input  logic [2*DW+$clog2(N)-1:0] mvm_result,
    output logic                      res_valid,
    output logic [2*DW+$clog2(N)-1:0] res_data,
    output logic [$clog2(N)-1:0]      res_idx,
    output logic                      res_last,
    output logic [2:0]                state_dbg
`ifdef MVM_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]               job_cnt
`endif
);

    localparam int TOTAL    = N * N + N;
    localparam int LCW      = $clog2(TOTAL + 1);
    localparam int SMAX     = (N > LAT) ? N : LAT;
    localparam int SW       = $clog2(SMAX + 1);
    localparam int IW       = $clog2(N);
    localparam int LAT_LAST = (LAT > 0) ? LAT - 1 : 0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        STREAM  = 3'd2,
        WAIT    = 3'd3,
        CAPTURE = 3'd4,
        DRAIN   = 3'd5
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [LCW-1:0]   load_cnt;
    logic [LCW-1:0]   load_next;
    logic [SW-1:0]    step;
    logic [SW-1:0]    step_next;
    logic             xfer;
    logic [DW-1:0]    data_buf [TOTAL];

    // Load handshake: an element moves only on a cycle where in_valid && in_ready; in_ready never
    // depends on in_valid, and the producer must hold in_data stable while in_valid is high.
    assign xfer      = in_valid && in_ready;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            load_cnt <= '0;
            step     <= '0;
        end else begin
            state    <= state_next;
            load_cnt <= load_next;
            step     <= step_next;
        end
    end

    always_comb begin
        state_next = state;
        load_next  = load_cnt;
        step_next  = step;
        case (state)
            IDLE: begin
                if (xfer) begin
                    load_next  = LCW'(1);
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (xfer) begin
                    if (load_cnt == LCW'(TOTAL - 1)) begin
                        load_next  = '0;
                        step_next  = '0;
                        state_next = STREAM;
                    end else begin
                        load_next = load_cnt + LCW'(1);
                    end
                end
            end
            STREAM: begin
                if (step == SW'(N - 1)) begin
                    step_next  = '0;
                    state_next = (LAT == 0) ? CAPTURE : WAIT;
                end else begin
                    step_next = step + SW'(1);
                end
            end
            WAIT: begin
                if (step == SW'(LAT_LAST)) begin
                    step_next  = '0;
                    state_next = CAPTURE;
                end else begin
                    step_next = step + SW'(1);
                end
            end
            CAPTURE: begin
                step_next  = '0;
                state_next = DRAIN;
            end
            DRAIN: begin
                if (step == SW'(N - 1)) begin
                    step_next  = '0;
                    state_next = IDLE;
                end else begin
                    step_next = step + SW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                load_next  = '0;
                step_next  = '0;
            end
        endcase
    end

    // Buffers are deliberately not reset; every job rewrites all TOTAL entries before streaming.
    always_ff @(posedge clk) begin
        if (xfer) begin
            for (int e = 0; e < TOTAL; e++) begin
                if (load_cnt == LCW'(e)) begin
                    data_buf[e] <= in_data;
                end
            end
        end
    end

    always_comb begin
        in_ready  = (state == IDLE) || (state == LOAD);
        vect_b    = '0;
        init      = 1'b0;
        shift_en  = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        res_idx   = '0;
        res_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            mat_a[i] = '0;
        end
        if (state == STREAM) begin
            init = (step == '0);
            for (int j = 0; j < N; j++) begin
                if (step == SW'(j)) begin
                    vect_b = data_buf[N*N + j];
                    for (int i = 0; i < N; i++) begin
                        mat_a[i] = data_buf[i*N + j];
                    end
                end
            end
        end
        if (state == DRAIN) begin
            shift_en  = 1'b1;
            res_valid = 1'b1;
            res_data  = mvm_result;
            res_idx   = step[IW-1:0];
            res_last  = (step == SW'(N - 1));
        end
    end

`ifdef MVM_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            job_cnt <= '0;
        end else if (state == DRAIN && step == SW'(N - 1)) begin
            job_cnt <= job_cnt + 32'd1;
        end
    end
`endif

endmodule
